// File: rtl/prga_stage.sv
// ---------------------------------------------------------------------------
// prga_stage
//
// RC4 pseudo-random generation stage. The S-box RAM has already been
// permuted by the upstream key-scheduling stage. This block reads a
// length-prefixed ciphertext message from a ROM, generates one keystream byte
// per message byte (updating S in place), and writes the plaintext to a RAM.
// It also reports whether every decrypted byte was printable ASCII.
//
// Ports
//   clk        : system clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   en         : start request, only honoured while rdy=1
//   rdy        : idle and able to accept en
//   ok         : last completed run produced only bytes in 0x20..0x7E
//   s_addr     : S RAM address (read and write)
//   s_rddata   : S RAM read data, one-cycle synchronous latency
//   s_wrdata   : S RAM write data
//   s_wren     : S RAM write enable
//   ct_addr    : ciphertext ROM address
//   ct_rddata  : ciphertext ROM data, one-cycle latency
//   pt_addr    : plaintext RAM address
//   pt_wrdata  : plaintext RAM write data
//   pt_wren    : plaintext RAM write enable
// ---------------------------------------------------------------------------
module prga_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       ok,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LEN,
    RD_SI,
    RD_SJ,
    WR_SWAP,
    RD_PAD,
    WR_PT,
    DONE
  } state_t;

  state_t     state_q, state_d;

  // Sub-step within a state. For read states phase 0 is the cycle in which
  // the memory samples the address and phase 1 is when its data is valid.
  // In WR_SWAP phase 0 drives the S[i] write and phase 1 drives the S[j] write.
  logic       phase_q, phase_d;

  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] ct_q, ct_d;
  logic [7:0] len_q, len_d;
  logic [7:0] k_q, k_d;
  logic       ok_run_q, ok_run_d;

  logic       rdy_q, rdy_d;
  logic       ok_q, ok_d;
  logic [7:0] s_addr_q, s_addr_d;
  logic [7:0] s_wrdata_q, s_wrdata_d;
  logic       s_wren_q, s_wren_d;
  logic [7:0] ct_addr_q, ct_addr_d;
  logic [7:0] pt_addr_q, pt_addr_d;
  logic [7:0] pt_wrdata_q, pt_wrdata_d;
  logic       pt_wren_q, pt_wren_d;

  logic [7:0] pt_byte;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // Next-state and next-output logic. All outputs are registered, so every
  // memory access is set up here one cycle before it appears on the ports.
  always_comb begin
    state_d     = state_q;
    phase_d     = 1'b0;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    ct_d        = ct_q;
    len_d       = len_q;
    k_d         = k_q;
    ok_run_d    = ok_run_q;
    rdy_d       = rdy_q;
    ok_d        = ok_q;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = 1'b0;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    pt_wren_d   = 1'b0;

    // S[(S[i]+S[j])] arrives on s_rddata during RD_PAD phase 1
    pt_byte     = s_rddata ^ ct_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = RD_LEN;
          rdy_d     = 1'b0;
          i_d       = 8'h00;
          j_d       = 8'h00;
          ok_run_d  = 1'b1;
          ct_addr_d = 8'h00;
        end
      end

      RD_LEN: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          len_d       = ct_rddata;
          k_d         = 8'h00;
          pt_addr_d   = 8'h00;
          pt_wrdata_d = ct_rddata;
          pt_wren_d   = 1'b1;
          state_d     = WR_PT;
        end
      end

      // i was already advanced and placed on s_addr when entering this
      // state; the ciphertext byte k is fetched in parallel.
      RD_SI: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          si_d     = s_rddata;
          ct_d     = ct_rddata;
          j_d      = j_q + s_rddata;
          s_addr_d = j_q + s_rddata;
          state_d  = RD_SJ;
        end
      end

      RD_SJ: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          sj_d       = s_rddata;
          s_addr_d   = i_q;
          s_wrdata_d = s_rddata;
          s_wren_d   = 1'b1;
          state_d    = WR_SWAP;
        end
      end

      // After the swap S[i]=sj and S[j]=si, so the pad index is si+sj
      // whichever way round. The pad read is issued a cycle after the
      // S[j] write, so it always sees the updated contents.
      WR_SWAP: begin
        if (!phase_q) begin
          phase_d    = 1'b1;
          s_addr_d   = j_q;
          s_wrdata_d = si_q;
          s_wren_d   = 1'b1;
        end else begin
          s_addr_d = si_q + sj_q;
          state_d  = RD_PAD;
        end
      end

      RD_PAD: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          pt_addr_d   = k_q;
          pt_wrdata_d = pt_byte;
          pt_wren_d   = 1'b1;
          if (!is_printable(pt_byte)) begin
            ok_run_d = 1'b0;
          end
          state_d = WR_PT;
        end
      end

      // k is the index just written; k=0 is the length byte, which is
      // excluded from the printable check.
      WR_PT: begin
        if (k_q == len_q) begin
          state_d = DONE;
        end else begin
          k_d       = k_q + 8'd1;
          i_d       = i_q + 8'd1;
          s_addr_d  = i_q + 8'd1;
          ct_addr_d = k_q + 8'd1;
          state_d   = RD_SI;
        end
      end

      DONE: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
        ok_d    = ok_run_q;
      end

      default: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      i_q         <= 8'h00;
      j_q         <= 8'h00;
      si_q        <= 8'h00;
      sj_q        <= 8'h00;
      ct_q        <= 8'h00;
      len_q       <= 8'h00;
      k_q         <= 8'h00;
      ok_run_q    <= 1'b0;
      rdy_q       <= 1'b1;
      ok_q        <= 1'b0;
      s_addr_q    <= 8'h00;
      s_wrdata_q  <= 8'h00;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= 8'h00;
      pt_addr_q   <= 8'h00;
      pt_wrdata_q <= 8'h00;
      pt_wren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      ct_q        <= ct_d;
      len_q       <= len_d;
      k_q         <= k_d;
      ok_run_q    <= ok_run_d;
      rdy_q       <= rdy_d;
      ok_q        <= ok_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
      pt_wren_q   <= pt_wren_d;
    end
  end

  assign rdy       = rdy_q;
  assign ok        = ok_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign ct_addr   = ct_addr_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;

endmodule

// File: tb/tb_prga_stage.sv
// ---------------------------------------------------------------------------
// tb_prga_stage
//
// Directed bench for prga_stage. Provides behavioural S RAM, ciphertext ROM
// and plaintext RAM with one-cycle synchronous reads, and checks decrypted
// bytes, S contents, ok flag and handshake timing against hand-computed
// RC4 PRGA values for an identity S-box.
// ---------------------------------------------------------------------------
module tb_prga_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic       ok;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  logic [7:0] s_mem  [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic       s_init;
  logic       pt_clear;
  int         s_wr_count;
  int         pt_wr_count;
  int         pt0_wr_count;

  int         pass_cnt;
  int         total_cnt;

  prga_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .ok        (ok),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  always #5 clk = ~clk;

  // Memory models: synchronous read returns pre-write data on a same-cycle
  // collision, so any read-before-write hazard in the DUT would show up.
  always @(posedge clk) begin
    if (s_init) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
      s_wr_count <= 0;
    end else if (s_wren) begin
      s_mem[s_addr] <= s_wrdata;
      s_wr_count    <= s_wr_count + 1;
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (pt_clear) begin
      for (int x = 0; x < 256; x++) pt_mem[x] <= 8'hEE;
      pt_wr_count  <= 0;
      pt0_wr_count <= 0;
    end else if (pt_wren) begin
      pt_mem[pt_addr] <= pt_wrdata;
      pt_wr_count     <= pt_wr_count + 1;
      if (pt_addr == 8'h00) pt0_wr_count <= pt0_wr_count + 1;
    end
  end

  // Reload identity S and clear the plaintext RAM and write counters.
  task automatic prep();
    @(negedge clk);
    s_init   = 1'b1;
    pt_clear = 1'b1;
    @(posedge clk);
    #1;
    s_init   = 1'b0;
    pt_clear = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  // Counts rising edges after the start edge until rdy is seen high.
  task automatic wait_rdy(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!rdy && cycles < 400);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    #2;
    total_cnt++; if (rdy !== 1'b1) $display("[TB] FAIL reset_rdy: got %b want 1", rdy); else pass_cnt++;
    total_cnt++; if (ok !== 1'b0) $display("[TB] FAIL reset_ok: got %b want 0", ok); else pass_cnt++;
    total_cnt++; if (s_wren !== 1'b0) $display("[TB] FAIL reset_s_wren: got %b want 0", s_wren); else pass_cnt++;
    total_cnt++; if (pt_wren !== 1'b0) $display("[TB] FAIL reset_pt_wren: got %b want 0", pt_wren); else pass_cnt++;
    total_cnt++; if ({s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata} !== 40'h0)
      $display("[TB] FAIL reset_addr_data: got %h want 0", {s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (rdy !== 1'b1) $display("[TB] FAIL idle_rdy: got %b want 1", rdy); else pass_cnt++;
  endtask

  task automatic test_single_byte();
    int cyc;
    $display("[TB] test_single_byte");
    prep();
    ct_mem[0] = 8'h01;
    ct_mem[1] = 8'h41;
    start_run();
    total_cnt++; if (rdy !== 1'b0) $display("[TB] FAIL busy_rdy: got %b want 0", rdy); else pass_cnt++;
    wait_rdy(cyc);
    total_cnt++; if (rdy !== 1'b1) $display("[TB] FAIL one_timeout: got rdy %b want 1", rdy); else pass_cnt++;
    total_cnt++; if (cyc > 16) $display("[TB] FAIL one_latency: got %0d cycles want <=16", cyc); else pass_cnt++;
    total_cnt++; if (pt_mem[0] !== 8'h01) $display("[TB] FAIL one_pt0: got %h want 01", pt_mem[0]); else pass_cnt++;
    total_cnt++; if (pt_mem[1] !== 8'h43) $display("[TB] FAIL one_pt1: got %h want 43", pt_mem[1]); else pass_cnt++;
    total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL one_ok: got %b want 1", ok); else pass_cnt++;
    total_cnt++; if (pt_wr_count != 2) $display("[TB] FAIL one_pt_writes: got %0d want 2", pt_wr_count); else pass_cnt++;
    total_cnt++; if (s_wr_count != 2) $display("[TB] FAIL one_s_writes: got %0d want 2", s_wr_count); else pass_cnt++;
  endtask

  task automatic test_two_byte();
    int cyc;
    $display("[TB] test_two_byte");
    prep();
    ct_mem[0] = 8'h02;
    ct_mem[1] = 8'h41;
    ct_mem[2] = 8'h42;
    start_run();
    wait_rdy(cyc);
    total_cnt++; if (rdy !== 1'b1 || cyc > 26) $display("[TB] FAIL two_latency: got %0d cycles rdy %b want <=26 rdy 1", cyc, rdy); else pass_cnt++;
    total_cnt++; if (pt_mem[1] !== 8'h43) $display("[TB] FAIL two_pt1: got %h want 43", pt_mem[1]); else pass_cnt++;
    total_cnt++; if (pt_mem[2] !== 8'h47) $display("[TB] FAIL two_pt2: got %h want 47", pt_mem[2]); else pass_cnt++;
    total_cnt++; if (s_mem[2] !== 8'h03) $display("[TB] FAIL two_s2: got %h want 03", s_mem[2]); else pass_cnt++;
    total_cnt++; if (s_mem[3] !== 8'h02) $display("[TB] FAIL two_s3: got %h want 02", s_mem[3]); else pass_cnt++;
    total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL two_ok: got %b want 1", ok); else pass_cnt++;
  endtask

  task automatic test_nonprintable();
    int cyc;
    $display("[TB] test_nonprintable");
    prep();
    ct_mem[0] = 8'h01;
    ct_mem[1] = 8'h02;
    start_run();
    wait_rdy(cyc);
    total_cnt++; if (rdy !== 1'b1) $display("[TB] FAIL np_timeout: got rdy %b want 1", rdy); else pass_cnt++;
    total_cnt++; if (ok !== 1'b0) $display("[TB] FAIL np_ok_at_rdy: got %b want 0", ok); else pass_cnt++;
    total_cnt++; if (pt_mem[1] !== 8'h00) $display("[TB] FAIL np_pt1: got %h want 00", pt_mem[1]); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (ok !== 1'b0) $display("[TB] FAIL np_ok_hold: got %b want 0", ok); else pass_cnt++;
  endtask

  task automatic test_zero_len();
    int cyc;
    $display("[TB] test_zero_len");
    prep();
    ct_mem[0] = 8'h00;
    start_run();
    wait_rdy(cyc);
    total_cnt++; if (rdy !== 1'b1 || cyc > 6) $display("[TB] FAIL zero_latency: got %0d cycles rdy %b want <=6 rdy 1", cyc, rdy); else pass_cnt++;
    total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL zero_ok: got %b want 1", ok); else pass_cnt++;
    total_cnt++; if (pt_mem[0] !== 8'h00) $display("[TB] FAIL zero_pt0: got %h want 00", pt_mem[0]); else pass_cnt++;
    total_cnt++; if (pt_wr_count != 1) $display("[TB] FAIL zero_pt_writes: got %0d want 1", pt_wr_count); else pass_cnt++;
    total_cnt++; if (s_wr_count != 0) $display("[TB] FAIL zero_s_writes: got %0d want 0", s_wr_count); else pass_cnt++;
    total_cnt++; if (pt_mem[1] !== 8'hEE) $display("[TB] FAIL zero_pt1_untouched: got %h want ee", pt_mem[1]); else pass_cnt++;
  endtask

  // "Hello" under identity S: pads are 02,05,07,0D,0D.
  task automatic test_abort();
    int         cyc;
    logic [7:0] exp_pt [6];
    $display("[TB] test_abort");
    exp_pt[0] = 8'h05; exp_pt[1] = 8'h48; exp_pt[2] = 8'h65;
    exp_pt[3] = 8'h6C; exp_pt[4] = 8'h6C; exp_pt[5] = 8'h6F;
    prep();
    ct_mem[0] = 8'h05; ct_mem[1] = 8'h4A; ct_mem[2] = 8'h60;
    ct_mem[3] = 8'h6B; ct_mem[4] = 8'h61; ct_mem[5] = 8'h62;
    start_run();
    repeat (15) @(posedge clk);
    #3;
    total_cnt++; if (rdy !== 1'b0) $display("[TB] FAIL abort_busy: got rdy %b want 0", rdy); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (rdy !== 1'b1) $display("[TB] FAIL abort_rdy: got %b want 1", rdy); else pass_cnt++;
    total_cnt++; if (ok !== 1'b0) $display("[TB] FAIL abort_ok: got %b want 0", ok); else pass_cnt++;
    total_cnt++; if (s_wren !== 1'b0 || pt_wren !== 1'b0) $display("[TB] FAIL abort_wren: got %b%b want 00", s_wren, pt_wren); else pass_cnt++;
    total_cnt++; if (s_addr !== 8'h00) $display("[TB] FAIL abort_s_addr: got %h want 00", s_addr); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    prep();
    start_run();
    wait_rdy(cyc);
    total_cnt++; if (rdy !== 1'b1 || cyc > 56) $display("[TB] FAIL restart_latency: got %0d cycles rdy %b want <=56 rdy 1", cyc, rdy); else pass_cnt++;
    for (int n = 0; n < 6; n++) begin
      total_cnt++;
      if (pt_mem[n] !== exp_pt[n]) $display("[TB] FAIL restart_pt%0d: got %h want %h", n, pt_mem[n], exp_pt[n]);
      else pass_cnt++;
    end
    total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL restart_ok: got %b want 1", ok); else pass_cnt++;
    total_cnt++; if (s_mem[3] !== 8'h05) $display("[TB] FAIL restart_s3: got %h want 05", s_mem[3]); else pass_cnt++;
    total_cnt++; if (s_mem[11] !== 8'h02) $display("[TB] FAIL restart_s11: got %h want 02", s_mem[11]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int   starts;
    int   dbl;
    int   cyc;
    logic prev;
    $display("[TB] test_back_to_back");
    prep();
    ct_mem[0] = 8'h01;
    ct_mem[1] = 8'h41;
    starts = 0;
    dbl    = 0;
    prev   = 1'b0;
    @(negedge clk);
    en = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (rdy) begin
        starts++;
        if (prev) dbl++;
      end
      prev = rdy;
      @(negedge clk);
    end
    en = 1'b0;
    if (!rdy) wait_rdy(cyc);
    #1;
    total_cnt++; if (rdy !== 1'b1) $display("[TB] FAIL b2b_timeout: got rdy %b want 1", rdy); else pass_cnt++;
    total_cnt++; if (starts < 3) $display("[TB] FAIL b2b_starts: got %0d want >=3", starts); else pass_cnt++;
    total_cnt++; if (dbl != 0) $display("[TB] FAIL b2b_idle_gap: got %0d long idles want 0", dbl); else pass_cnt++;
    total_cnt++; if (pt0_wr_count != starts) $display("[TB] FAIL b2b_runs: got %0d runs want %0d", pt0_wr_count, starts); else pass_cnt++;
    total_cnt++; if (pt_wr_count != 2 * starts) $display("[TB] FAIL b2b_pt_writes: got %0d want %0d", pt_wr_count, 2 * starts); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    en        = 1'b0;
    s_init    = 1'b0;
    pt_clear  = 1'b0;
    rst_n     = 1'b1;
    #1;
    rst_n     = 1'b0;
    test_reset();
    test_single_byte();
    test_two_byte();
    test_nonprintable();
    test_zero_len();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
